gpu_bus_arbiter: RTL and testbench
==================================

# gpu_bus_arbiter

Parametrised interconnect between NUM_CORES GCore data ports, the VGA scan-out reader, the SRAM controller port and the GPU coprocessor port. Each core request is routed by its top address bit to the memory target (bit clear) or the coprocessor target (bit set). Each target has its own arbiter: VGA has fixed highest priority on memory, and cores are served round-robin. A per-target watchdog completes hung transactions. It replaces the hard-wired two-core address-bit steering in the GPU top level.

## Interface
- NUM_CORES, 2: number of core data ports (1..8).
- ADDR_W, 21: core address width; bit ADDR_W-1 selects the target.
- DATA_W, 48: data width.
- TIMEOUT, 0: watchdog limit in cycles; 0 disables the watchdog.

- clk  in  1  single clock
- rst  in  1  asynchronous, active-low reset
- core_addr  in  NUM_CORES*ADDR_W  per-core address, core i in slice i
- core_wdata  in  NUM_CORES*DATA_W  per-core write data
- core_we / core_rd  in  NUM_CORES  per-core write / read request
- core_rdata  out  NUM_CORES*DATA_W  per-core read data, valid while core_ready[i] is high and that core is requesting
- core_ready  out  NUM_CORES  transfer complete, or core not requesting
- vga_addr  in  ADDR_W-1  VGA read address
- vga_sel  in  1  VGA read request
- vga_data  out  DATA_W  VGA read data
- vga_valid  out  1  VGA read complete
- mem_addr  out  ADDR_W-1  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_sel / mem_we  out  1  memory select / write
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory transfer complete
- cp_addr  out  ADDR_W-1  coprocessor address
- cp_wdata  out  DATA_W  coprocessor write data
- cp_sel / cp_we  out  1  coprocessor select / write
- cp_rdata  in  DATA_W  coprocessor read data
- cp_ready  in  1  coprocessor transfer complete
- err  out  2  sticky watchdog flags: bit 0 memory, bit 1 coprocessor

## Operation
- Core i requests when core_we[i] or core_rd[i] is high. Its target is core_addr[i][ADDR_W-1].
- A requesting core holds addr, data, we and rd stable until the cycle it sees core_ready[i] high, then deasserts or issues a new request.
- A non-requesting core sees core_ready[i]=1. A requesting core sees core_ready[i]=0 except in its completion cycle.
- Each target runs an independent FSM with states IDLE and BUSY, plus a registered owner, a round-robin pointer rr (0..NUM_CORES-1) and a watchdog counter.
- IDLE, memory target:
  - If vga_sel is high: owner=VGA, go to BUSY.
  - Else: the first requesting core targeting memory, searching from rr upward with wrap, becomes owner; go to BUSY.
  - If there are no requesters: stay in IDLE.
- IDLE, coprocessor target: same rule without VGA.
- BUSY:
  - mem_sel (or cp_sel) is 1. Address, wdata and we are driven combinationally from the owner's live inputs; the VGA owner drives we=0 and wdata=0.
  - The target's address output is the owner's address with the select bit stripped.
- Completion occurs in the cycle target ready=1 while BUSY:
  - Owner core: core_ready[owner]=1 and core_rdata[owner]=target rdata in that same cycle.
  - VGA owner: vga_valid=1 and vga_data=mem_rdata.
  - Next state is IDLE. If the owner was a core, rr becomes (owner+1) mod NUM_CORES; a VGA owner leaves rr unchanged.
- Watchdog: when TIMEOUT>0, the counter clears on entry to BUSY and increments each BUSY cycle without ready.
  - When it reaches TIMEOUT, the arbiter forces completion to the owner with rdata all-ones.
  - It also sets the target's err bit and returns to IDLE.
  - The err bits clear only on reset.
- Both targets may complete in the same cycle for different cores.
- A core granted on one target cannot appear on the other, because its request is stable.
- Outputs in IDLE: sel=0, we=0, addr=0, wdata=0.

## Timing
- Reset (rst low, asynchronous): both FSMs IDLE, rr=0, watchdog counters 0, err=0.
  - While reset is held, the outputs are: mem_sel=cp_sel=0, vga_valid=0, core_ready all 1, all data and address outputs 0.
  - Reset asserted mid-transaction drops sel immediately and abandons the transfer; no completion is signalled.
- Grant latency: a request seen in IDLE at edge n produces sel=1 from cycle n+1.
- Minimum transaction is 2 cycles (one IDLE arbitration cycle, then BUSY with ready=1).
- After a completion, the target spends one IDLE cycle before re-granting, so back-to-back memory accesses run one per 2 cycles at best.
- rr wraps from NUM_CORES-1 to 0.
- Starvation bounds:
  - VGA: waits at most for one in-flight core transfer.
  - Cores: wait behind at most NUM_CORES-1 other cores plus intervening VGA transfers.

## Test plan
- Reset with all requests low: core_ready=all 1, mem_sel=cp_sel=0, err=0. Assert rst mid-BUSY: mem_sel drops to 0 in the same cycle.
- Core0 reads addr 0x00010 with mem_ready returned 2 cycles after sel and mem_rdata=0xABCDEF012345: mem_addr=0x00010, core_ready[0] and core_rdata[0] valid in exactly the mem_ready cycle.
- Cores 0 and 1 both continuously request memory (NUM_CORES=2): grants alternate 0,1,0,1. Core1 requests the coprocessor (addr 0x100004) at the same time core0 accesses memory: both complete independently, with cp_addr=0x00004.
- vga_sel and core0 request memory in the same IDLE cycle: VGA is granted first, vga_valid then asserts with mem_rdata; core0 is served next.
- TIMEOUT=8, cp_ready held 0 on a core0 coprocessor write: core_ready[0]=1 with rdata=all-ones after 8 BUSY cycles, err=2'b10 stays set until reset.
- NUM_CORES=4, all four cores request memory with rr=3: grant order is 3,0,1,2.

Source files
------------

// File: rtl/gpu_bus_arbiter.sv
// Routes NUM_CORES core ports plus VGA scan-out onto the memory and coprocessor targets.
// Each target has its own IDLE/BUSY arbiter: VGA first on memory, then cores round-robin, with a watchdog.
//
//    state | meaning
//    IDLE  | no transfer; arbitrate among requesters, grant takes effect next cycle
//    BUSY  | owner drives the target; leave on target ready or watchdog expiry
module gpu_bus_arbiter #(
   parameter int NUM_CORES = 2,
   parameter int ADDR_W    = 21,
   parameter int DATA_W    = 48,
   parameter int TIMEOUT   = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
   input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
   input  logic [NUM_CORES-1:0]          core_we,
   input  logic [NUM_CORES-1:0]          core_rd,
   output logic [NUM_CORES*DATA_W-1:0]   core_rdata,
   output logic [NUM_CORES-1:0]          core_ready,
   input  logic [ADDR_W-2:0]             vga_addr,
   input  logic                          vga_sel,
   output logic [DATA_W-1:0]             vga_data,
   output logic                          vga_valid,
   output logic [ADDR_W-2:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   output logic                          mem_sel,
   output logic                          mem_we,
   input  logic [DATA_W-1:0]             mem_rdata,
   input  logic                          mem_ready,
   output logic [ADDR_W-2:0]             cp_addr,
   output logic [DATA_W-1:0]             cp_wdata,
   output logic                          cp_sel,
   output logic                          cp_we,
   input  logic [DATA_W-1:0]             cp_rdata,
   input  logic                          cp_ready,
   output logic [1:0]                    err
);

   localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int AW = ADDR_W - 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state_q [2];
   state_t          state_d [2];
   logic [CW-1:0]   owner_q [2];
   logic [CW-1:0]   owner_d [2];
   logic [CW-1:0]   rr_q    [2];
   logic [CW-1:0]   rr_d    [2];
   logic [TW-1:0]   wd_q    [2];
   logic [TW-1:0]   wd_d    [2];
   logic            vga_own_q, vga_own_d;
   logic [1:0]      err_q, err_d;

   logic [NUM_CORES-1:0] req, tgt;
   logic [1:0]           tgt_ready, done, tmo, found;
   logic [DATA_W-1:0]    tgt_rdata [2];
   logic [DATA_W-1:0]    done_data [2];
   logic [AW-1:0]        t_addr    [2];
   logic [DATA_W-1:0]    t_wdata   [2];
   logic [1:0]           t_we;

   function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NUM_CORES) s = s - NUM_CORES;
      return CW'(s);
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_CORES; i++) begin
         req[i] = core_we[i] | core_rd[i];
         tgt[i] = core_addr[i*ADDR_W + ADDR_W - 1];
      end
      tgt_ready    = {cp_ready, mem_ready};
      tgt_rdata[0] = mem_rdata;
      tgt_rdata[1] = cp_rdata;
   end

   always_comb begin
      vga_own_d = vga_own_q;
      err_d     = err_q;
      done      = '0;
      tmo       = '0;
      found     = '0;
      t_we      = '0;
      for (int t = 0; t < 2; t++) begin
         state_d[t]   = state_q[t];
         owner_d[t]   = owner_q[t];
         rr_d[t]      = rr_q[t];
         wd_d[t]      = wd_q[t];
         done_data[t] = '0;
         t_addr[t]    = '0;
         t_wdata[t]   = '0;
         case (state_q[t])
            IDLE: begin
               if (t == 0 && vga_sel) begin
                  vga_own_d  = 1'b1;
                  state_d[t] = BUSY;
                  wd_d[t]    = '0;
               end else begin
                  for (int k = 0; k < NUM_CORES; k++) begin
                     if (!found[t] && req[wrap_add(rr_q[t], k)] &&
                         (tgt[wrap_add(rr_q[t], k)] == t[0])) begin
                        found[t]   = 1'b1;
                        owner_d[t] = wrap_add(rr_q[t], k);
                     end
                  end
                  if (found[t]) begin
                     state_d[t] = BUSY;
                     wd_d[t]    = '0;
                     if (t == 0) vga_own_d = 1'b0;
                  end
               end
            end
            BUSY: begin
               if (t == 0 && vga_own_q) begin
                  t_addr[t] = vga_addr;
               end else begin
                  t_addr[t]  = core_addr[int'(owner_q[t])*ADDR_W +: AW];
                  t_wdata[t] = core_wdata[int'(owner_q[t])*DATA_W +: DATA_W];
                  t_we[t]    = core_we[owner_q[t]];
               end
               // A real ready in the expiry cycle wins: genuine data, no error flag.
               tmo[t]  = (TIMEOUT > 0) && (wd_q[t] == TW'(TIMEOUT)) && !tgt_ready[t];
               done[t] = tgt_ready[t] | tmo[t];
               if (done[t]) begin
                  state_d[t]   = IDLE;
                  done_data[t] = tmo[t] ? '1 : tgt_rdata[t];
                  if (!(t == 0 && vga_own_q))
                     rr_d[t] = (int'(owner_q[t]) == NUM_CORES - 1) ? '0 : owner_q[t] + 1'b1;
                  if (tmo[t]) err_d[t] = 1'b1;
               end else if (TIMEOUT > 0) begin
                  wd_d[t] = wd_q[t] + 1'b1;
               end
            end
            default: state_d[t] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int t = 0; t < 2; t++) begin
            state_q[t] <= IDLE;
            owner_q[t] <= '0;
            rr_q[t]    <= '0;
            wd_q[t]    <= '0;
         end
         vga_own_q <= 1'b0;
         err_q     <= '0;
      end else begin
         for (int t = 0; t < 2; t++) begin
            state_q[t] <= state_d[t];
            owner_q[t] <= owner_d[t];
            rr_q[t]    <= rr_d[t];
            wd_q[t]    <= wd_d[t];
         end
         vga_own_q <= vga_own_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      mem_sel   = (state_q[0] == BUSY);
      mem_we    = t_we[0];
      mem_addr  = t_addr[0];
      mem_wdata = t_wdata[0];
      cp_sel    = (state_q[1] == BUSY);
      cp_we     = t_we[1];
      cp_addr   = t_addr[1];
      cp_wdata  = t_wdata[1];
      vga_valid = done[0] & vga_own_q;
      vga_data  = vga_valid ? done_data[0] : '0;
      err       = err_q;
      core_rdata = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         core_ready[i] = !req[i];
         for (int t = 0; t < 2; t++) begin
            if (done[t] && !(t == 0 && vga_own_q) && (owner_q[t] == CW'(i))) begin
               core_ready[i] = 1'b1;
               core_rdata[i*DATA_W +: DATA_W] = done_data[t];
            end
         end
      end
      // Reset forces every core to see ready so nothing stalls on a stale handshake.
      if (!rst) core_ready = '1;
   end

endmodule

// File: tb/tb_gpu_bus_arbiter.sv
// Directed bench for gpu_bus_arbiter: a two-core instance with an 8-cycle watchdog
// and a four-core instance for the round-robin wrap order.
module tb_gpu_bus_arbiter;

   logic clk, rst;

   logic [41:0]  c_addr;
   logic [95:0]  c_wdata;
   logic [1:0]   c_we, c_rd;
   logic [95:0]  c_rdata;
   logic [1:0]   c_ready;
   logic [19:0]  vga_addr;
   logic         vga_sel;
   logic [47:0]  vga_data;
   logic         vga_valid;
   logic [19:0]  mem_addr;
   logic [47:0]  mem_wdata;
   logic         mem_sel, mem_we;
   logic [47:0]  mem_rdata;
   logic         mem_ready;
   logic [19:0]  cp_addr;
   logic [47:0]  cp_wdata;
   logic         cp_sel, cp_we;
   logic [47:0]  cp_rdata;
   logic         cp_ready;
   logic [1:0]   err;

   logic [83:0]  d4_addr;
   logic [191:0] d4_wdata;
   logic [3:0]   d4_we, d4_rd;
   logic [191:0] d4_rdata;
   logic [3:0]   d4_ready;
   logic [19:0]  d4_vga_addr;
   logic         d4_vga_sel;
   logic [47:0]  d4_vga_data;
   logic         d4_vga_valid;
   logic [19:0]  d4_mem_addr;
   logic [47:0]  d4_mem_wdata;
   logic         d4_mem_sel, d4_mem_we;
   logic [47:0]  d4_mem_rdata;
   logic         d4_mem_ready;
   logic [19:0]  d4_cp_addr;
   logic [47:0]  d4_cp_wdata;
   logic         d4_cp_sel, d4_cp_we;
   logic [47:0]  d4_cp_rdata;
   logic         d4_cp_ready;
   logic [1:0]   d4_err;

   int n_pass = 0;
   int n_total = 0;

   gpu_bus_arbiter #(.NUM_CORES(2), .ADDR_W(21), .DATA_W(48), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .core_addr(c_addr), .core_wdata(c_wdata), .core_we(c_we), .core_rd(c_rd),
      .core_rdata(c_rdata), .core_ready(c_ready),
      .vga_addr(vga_addr), .vga_sel(vga_sel), .vga_data(vga_data), .vga_valid(vga_valid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .cp_addr(cp_addr), .cp_wdata(cp_wdata), .cp_sel(cp_sel), .cp_we(cp_we),
      .cp_rdata(cp_rdata), .cp_ready(cp_ready),
      .err(err)
   );

   gpu_bus_arbiter #(.NUM_CORES(4), .ADDR_W(21), .DATA_W(48), .TIMEOUT(0)) dut4 (
      .clk(clk), .rst(rst),
      .core_addr(d4_addr), .core_wdata(d4_wdata), .core_we(d4_we), .core_rd(d4_rd),
      .core_rdata(d4_rdata), .core_ready(d4_ready),
      .vga_addr(d4_vga_addr), .vga_sel(d4_vga_sel), .vga_data(d4_vga_data),
      .vga_valid(d4_vga_valid),
      .mem_addr(d4_mem_addr), .mem_wdata(d4_mem_wdata), .mem_sel(d4_mem_sel),
      .mem_we(d4_mem_we), .mem_rdata(d4_mem_rdata), .mem_ready(d4_mem_ready),
      .cp_addr(d4_cp_addr), .cp_wdata(d4_cp_wdata), .cp_sel(d4_cp_sel), .cp_we(d4_cp_we),
      .cp_rdata(d4_cp_rdata), .cp_ready(d4_cp_ready),
      .err(d4_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      int exp2 [4];
      int exp4 [4];
      exp2 = '{1, 0, 1, 0};
      exp4 = '{3, 0, 1, 2};

      rst = 1'b0;
      c_addr = '0; c_wdata = '0; c_we = '0; c_rd = '0;
      vga_addr = '0; vga_sel = 1'b0;
      mem_rdata = '0; mem_ready = 1'b0; cp_rdata = '0; cp_ready = 1'b0;
      d4_addr = '0; d4_wdata = '0; d4_we = '0; d4_rd = '0;
      d4_vga_addr = '0; d4_vga_sel = 1'b0;
      d4_mem_rdata = '0; d4_mem_ready = 1'b0; d4_cp_rdata = '0; d4_cp_ready = 1'b0;

      // reset held, with core0 requesting
      #2 c_rd = 2'b01;
      smp();
      chk("rst_core_ready", c_ready, 2'b11);
      chk("rst_mem_sel", mem_sel, 1'b0);
      chk("rst_cp_sel", cp_sel, 1'b0);
      chk("rst_err", err, 2'b00);
      chk("rst_vga_valid", vga_valid, 1'b0);
      chk("rst_mem_addr", mem_addr, 20'h0);
      c_rd = 2'b00;
      #2 rst = 1'b1;

      // core0 read, memory answers two cycles after sel
      step();
      c_rd = 2'b01; c_addr[20:0] = 21'h00010;
      smp();
      chk("t1_idle_sel", mem_sel, 1'b0);
      chk("t1_idle_ready", c_ready, 2'b10);
      step(); smp();
      chk("t1_busy_sel", mem_sel, 1'b1);
      chk("t1_busy_addr", mem_addr, 20'h00010);
      chk("t1_busy_ready", c_ready, 2'b10);
      step(); smp();
      chk("t1_wait_ready", c_ready, 2'b10);
      step();
      mem_ready = 1'b1; mem_rdata = 48'hABCDEF012345;
      smp();
      chk("t1_done_ready", c_ready, 2'b11);
      chk("t1_done_rdata", c_rdata[47:0], 48'hABCDEF012345);
      step();
      c_rd = 2'b00; mem_ready = 1'b0; mem_rdata = '0;
      smp();
      chk("t1_after_sel", mem_sel, 1'b0);

      // both cores hammer memory: rr is 1 after core0's access
      step();
      c_rd = 2'b11; c_addr[20:0] = 21'h00020; c_addr[41:21] = 21'h00030; mem_ready = 1'b1;
      smp();
      chk("t2_idle0_sel", mem_sel, 1'b0);
      for (int g = 0; g < 4; g++) begin
         step(); smp();
         chk("t2_grant_ready", c_ready, 64'(2'b01 << exp2[g]));
         chk("t2_grant_addr", mem_addr, (exp2[g] == 0) ? 20'h00020 : 20'h00030);
         step();
         if (g == 3) begin
            c_rd = 2'b00; mem_ready = 1'b0;
         end
         smp();
         chk("t2_gap_sel", mem_sel, 1'b0);
      end

      // core0 on memory while core1 writes the coprocessor
      step();
      c_rd = 2'b01; c_addr[20:0] = 21'h00040;
      c_we = 2'b10; c_addr[41:21] = 21'h100004; c_wdata[95:48] = 48'h111122223333;
      mem_ready = 1'b1; mem_rdata = 48'h555566667777;
      smp();
      chk("t3_idle_ready", c_ready, 2'b00);
      step(); smp();
      chk("t3_mem_addr", mem_addr, 20'h00040);
      chk("t3_cp_sel", cp_sel, 1'b1);
      chk("t3_cp_addr", cp_addr, 20'h00004);
      chk("t3_cp_we", cp_we, 1'b1);
      chk("t3_cp_wdata", cp_wdata, 48'h111122223333);
      chk("t3_ready_mem_only", c_ready, 2'b01);
      chk("t3_rdata0", c_rdata[47:0], 48'h555566667777);
      step();
      c_rd = 2'b00; mem_ready = 1'b0; cp_ready = 1'b1;
      smp();
      chk("t3_mem_idle", mem_sel, 1'b0);
      chk("t3_cp_done_ready", c_ready, 2'b11);
      step();
      c_we = 2'b00; cp_ready = 1'b0;
      smp();
      chk("t3_cp_idle", cp_sel, 1'b0);

      // VGA and core0 collide on memory: VGA first
      step();
      vga_sel = 1'b1; vga_addr = 20'h0ABCD;
      c_rd = 2'b01; c_addr[20:0] = 21'h00050; c_wdata[47:0] = 48'h000000000999;
      mem_ready = 1'b1; mem_rdata = 48'h000000000777;
      smp();
      chk("t4_idle_sel", mem_sel, 1'b0);
      step(); smp();
      chk("t4_vga_addr", mem_addr, 20'h0ABCD);
      chk("t4_vga_wdata", mem_wdata, 48'h0);
      chk("t4_vga_valid", vga_valid, 1'b1);
      chk("t4_vga_data", vga_data, 48'h000000000777);
      chk("t4_core_wait", c_ready, 2'b10);
      step();
      vga_sel = 1'b0;
      smp();
      chk("t4_gap_valid", vga_valid, 1'b0);
      step(); smp();
      chk("t4_core_addr", mem_addr, 20'h00050);
      chk("t4_core_ready", c_ready, 2'b11);
      chk("t4_core_valid_low", vga_valid, 1'b0);
      step();
      c_rd = 2'b00; mem_ready = 1'b0;
      smp();

      // coprocessor never answers: watchdog completes after 8 waiting cycles
      step();
      c_we = 2'b01; c_addr[20:0] = 21'h100008; c_wdata[47:0] = 48'h000000000123;
      smp();
      for (int b = 1; b <= 9; b++) begin
         step(); smp();
         chk("t5_wd_ready", c_ready, (b == 9) ? 2'b11 : 2'b10);
         if (b == 9) begin
            chk("t5_wd_rdata", c_rdata[47:0], 48'hFFFFFFFFFFFF);
            chk("t5_err_pre", err, 2'b00);
         end
      end
      step();
      c_we = 2'b00;
      smp();
      chk("t5_err_set", err, 2'b10);
      chk("t5_cp_idle", cp_sel, 1'b0);
      step(); step(); smp();
      chk("t5_err_sticky", err, 2'b10);

      // reset mid-transaction
      step();
      c_rd = 2'b01; c_addr[20:0] = 21'h00070;
      smp();
      step(); smp();
      chk("t6_busy_sel", mem_sel, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("t6_rst_sel", mem_sel, 1'b0);
      chk("t6_rst_ready", c_ready, 2'b11);
      chk("t6_rst_err", err, 2'b00);
      c_rd = 2'b00;
      #1 rst = 1'b1;

      // four cores: core2 alone moves rr to 3, then all four contend
      step();
      d4_rd = 4'b0100; d4_addr[62:42] = 21'h00060;
      d4_mem_ready = 1'b1; d4_mem_rdata = 48'h000000002222;
      smp();
      step(); smp();
      chk("t7_c2_addr", d4_mem_addr, 20'h00060);
      chk("t7_c2_rdata", d4_rdata[143:96], 48'h000000002222);
      step();
      d4_rd = 4'b0000;
      smp();
      chk("t7_idle_sel", d4_mem_sel, 1'b0);
      step();
      d4_rd = 4'hF;
      d4_addr[20:0] = 21'h00100; d4_addr[41:21] = 21'h00101;
      d4_addr[62:42] = 21'h00102; d4_addr[83:63] = 21'h00103;
      smp();
      for (int g = 0; g < 4; g++) begin
         step(); smp();
         chk("t7_rr_ready", d4_ready, 64'(4'b0001 << exp4[g]));
         chk("t7_rr_addr", d4_mem_addr, 20'h00100 + 20'(exp4[g]));
         step();
         if (g == 3) begin
            d4_rd = 4'b0000; d4_mem_ready = 1'b0;
         end
         smp();
         chk("t7_gap_sel", d4_mem_sel, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed hang expected finish");
      $fatal(1, "bench time limit");
   end

endmodule
